// File: rtl/hit_judge.sv
// hit_judge -- whack-a-mole hit/miss referee.
//
// Eight raw push buttons are synchronized and debounced. A clean 0->1 of a
// debounced level is a press event, judged against the currently shown mole.
// A press on the mole's hole scores a hit and locks out further presses
// until the mole moves. Any other press, or a mole that moves away without
// having been hit, counts as a miss. Both counters saturate at 99.
//
// Parameters
//   CYCLES_PER_MS  clk_1mhz cycles per millisecond
//   DEBOUNCE_MS    time a button level must be stable before it is accepted
//
// Ports
//   clk_1mhz    in   1  system clock, all state on its rising edge
//   rst_n       in   1  asynchronous active-low reset
//   enable      in   1  game running; judging only while high
//   mole_pos    in   4  0 = no mole, 1..8 = hole index, 9..15 read as 0
//   btn         in   8  raw bouncing buttons, btn[k] is hole k+1
//   hit_pulse   out  1  one-cycle pulse on a hit
//   miss_pulse  out  1  one-cycle pulse on a wrong press and/or escape
//   score       out  7  hit count, saturating at 99
//   miss_cnt    out  7  miss count, saturating at 99
module hit_judge #(
  parameter int CYCLES_PER_MS = 1000,
  parameter int DEBOUNCE_MS   = 5
) (
  input  logic       clk_1mhz,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] mole_pos,
  input  logic [7:0] btn,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [6:0] score,
  output logic [6:0] miss_cnt
);

  localparam int DB_CYCLES = DEBOUNCE_MS * CYCLES_PER_MS;
  localparam int CNT_W     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [6:0] SAT = 7'd99;

  // ---------------------------------------------------------------------
  // Input synchronizer and debouncers
  // ---------------------------------------------------------------------
  logic [7:0]       sync_q1;
  logic [7:0]       sync_q2;
  logic [7:0]       stable;
  logic [7:0]       stable_d;
  logic [CNT_W-1:0] db_cnt [8];
  logic [7:0]       press_evt;

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge value of the others; blocking here would collapse the
  // two-flop synchronizer into a single flop.
  always_ff @(posedge clk_1mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
    end
  end

  // The counter runs only while the synchronized level disagrees with the
  // accepted level; any agreeing cycle restarts the wait from zero.
  always_ff @(posedge clk_1mhz or negedge rst_n) begin
    if (!rst_n) begin
      stable   <= '0;
      stable_d <= '0;
      // NOTE: db_cnt is a small flop array, not a RAM macro, so clearing it
      // in reset is cheap and required; a true memory would not be reset.
      for (int k = 0; k < 8; k++) begin
        db_cnt[k] <= '0;
      end
    end else begin
      stable_d <= stable;
      for (int k = 0; k < 8; k++) begin
        if (sync_q2[k] == stable[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == CNT_LAST) begin
          stable[k] <= sync_q2[k];
          db_cnt[k] <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  // Only rising edges of the accepted level are presses; releases are silent.
  assign press_evt = stable & ~stable_d;

  // ---------------------------------------------------------------------
  // Judge
  // ---------------------------------------------------------------------
  logic [3:0] prev_pos;
  logic       lock;
  logic       en_d;

  logic [3:0] mole_eff;
  logic       mole_changed;
  logic       lock_eff;
  logic [7:0] target_mask;
  logic       target_press;
  logic       wrong_press;
  logic       escape;
  logic       judge_on;
  logic       first_cycle;
  logic       hit_now;
  logic [1:0] miss_events;
  logic [7:0] miss_sum;
  logic [6:0] score_nxt;
  logic [6:0] miss_nxt;
  logic       lock_nxt;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    mole_eff     = '0;
    mole_changed = 1'b0;
    lock_eff     = 1'b0;
    target_mask  = '0;
    target_press = 1'b0;
    wrong_press  = 1'b0;
    escape       = 1'b0;
    judge_on     = 1'b0;
    first_cycle  = 1'b0;
    hit_now      = 1'b0;
    miss_events  = '0;
    miss_sum     = '0;
    score_nxt    = score;
    miss_nxt     = miss_cnt;
    lock_nxt     = 1'b0;

    if (mole_pos >= 4'd1 && mole_pos <= 4'd8) begin
      mole_eff = mole_pos;
    end

    // A new mole clears the lock in the same cycle, so a press that lands
    // exactly on the change is judged against the new mole.
    mole_changed = (mole_eff != prev_pos);
    lock_eff     = lock & ~mole_changed;

    if (mole_eff != 4'd0) begin
      target_mask = 8'(1) << (mole_eff - 4'd1);
    end
    target_press = |(press_evt & target_mask);
    // A target press among simultaneous presses makes the whole event a hit.
    wrong_press  = (|press_evt) & ~target_press;
    // Escape looks at the lock as it stood before the change.
    escape       = mole_changed & (prev_pos != 4'd0) & ~lock;

    // The first enabled cycle only clears the counters; nothing is judged.
    first_cycle = enable & ~en_d;
    judge_on    = enable & en_d;

    hit_now     = judge_on & ~lock_eff & target_press;
    miss_events = {1'b0, judge_on & escape}
                + {1'b0, judge_on & ~lock_eff & wrong_press};

    score_nxt = (score == SAT) ? SAT : score + 7'd1;
    miss_sum  = {1'b0, miss_cnt} + {6'd0, miss_events};
    miss_nxt  = (miss_sum > 8'd99) ? SAT : miss_sum[6:0];

    lock_nxt = judge_on & (hit_now | lock_eff);
  end

  always_ff @(posedge clk_1mhz or negedge rst_n) begin
    if (!rst_n) begin
      prev_pos   <= '0;
      lock       <= 1'b0;
      en_d       <= 1'b0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      score      <= '0;
      miss_cnt   <= '0;
    end else begin
      prev_pos   <= mole_eff;
      lock       <= lock_nxt;
      en_d       <= enable;
      hit_pulse  <= hit_now;
      // An escape coinciding with a hit is still counted, but the single
      // pulse slot goes to the hit so the two pulses never overlap.
      miss_pulse <= (miss_events != 2'd0) & ~hit_now;
      if (first_cycle) begin
        score    <= '0;
        miss_cnt <= '0;
      end else if (judge_on) begin
        if (hit_now) begin
          score <= score_nxt;
        end
        miss_cnt <= miss_nxt;
      end
    end
  end

endmodule

// File: tb/tb_hit_judge.sv
// Testbench for hit_judge. Timing is scaled through the parameters
// (10 cycles per ms, 5 ms debounce => 50-cycle debounce, 53-cycle latency)
// so the saturation and random phases stay short.
module tb_hit_judge;

  localparam int CPM = 10;
  localparam int DMS = 5;
  localparam int N   = CPM * DMS;
  localparam int LAT = 2 + N + 1;

  logic       clk_1mhz = 1'b0;
  logic       rst_n    = 1'b0;
  logic       enable   = 1'b0;
  logic [3:0] mole_pos = '0;
  logic [7:0] btn      = '0;
  logic       hit_pulse;
  logic       miss_pulse;
  logic [6:0] score;
  logic [6:0] miss_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_1mhz = ~clk_1mhz;

  hit_judge #(.CYCLES_PER_MS(CPM), .DEBOUNCE_MS(DMS)) dut (
    .clk_1mhz  (clk_1mhz),
    .rst_n     (rst_n),
    .enable    (enable),
    .mole_pos  (mole_pos),
    .btn       (btn),
    .hit_pulse (hit_pulse),
    .miss_pulse(miss_pulse),
    .score     (score),
    .miss_cnt  (miss_cnt)
  );

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: time-stamped debounce plus event-counting judge.
  // Advanced on the falling edge with the inputs the next rising edge will
  // sample; its outputs are compared with the DUT on the same falling edge.
  // ---------------------------------------------------------------------
  bit [7:0] m_q1, m_q2, m_stable, m_rise;
  int       m_since [8];
  int       cyc;
  int       m_prev, m_score, m_miss;
  bit       m_lock, m_en_d, m_hit, m_missp;

  task automatic model_reset();
    m_q1 = '0; m_q2 = '0; m_stable = '0; m_rise = '0;
    for (int k = 0; k < 8; k++) m_since[k] = -1;
    m_prev = 0; m_score = 0; m_miss = 0;
    m_lock = 0; m_en_d = 0; m_hit = 0; m_missp = 0;
  endtask

  task automatic model_step();
    bit [7:0] press;
    bit [7:0] new_rise;
    int       mole;
    int       n_miss;
    bit       changed, lock_now, hit;
    press    = m_rise;
    new_rise = '0;
    // A level is accepted once the synchronized copy has disagreed with the
    // accepted level for N consecutive cycles.
    for (int k = 0; k < 8; k++) begin
      if (m_q2[k] == m_stable[k]) begin
        m_since[k] = -1;
      end else begin
        if (m_since[k] < 0) m_since[k] = cyc;
        if (cyc - m_since[k] + 1 == N) begin
          m_stable[k] = m_q2[k];
          m_since[k]  = -1;
          new_rise[k] = m_stable[k];
        end
      end
    end
    m_q2   = m_q1;
    m_q1   = btn;
    m_rise = new_rise;

    mole    = (mole_pos >= 1 && mole_pos <= 8) ? int'(mole_pos) : 0;
    m_hit   = 0;
    m_missp = 0;
    if (!enable) begin
      m_lock = 0;
    end else if (!m_en_d) begin
      m_score = 0;
      m_miss  = 0;
      m_lock  = 0;
    end else begin
      changed  = (mole != m_prev);
      lock_now = changed ? 1'b0 : m_lock;
      n_miss   = 0;
      hit      = 0;
      if (changed && m_prev != 0 && !m_lock) n_miss++;
      if (!lock_now && press != 0) begin
        if (mole != 0 && press[mole-1]) hit = 1;
        else n_miss++;
      end
      m_score = hit ? ((m_score + 1 > 99) ? 99 : m_score + 1) : m_score;
      m_miss  = (m_miss + n_miss > 99) ? 99 : m_miss + n_miss;
      m_hit   = hit;
      m_missp = (n_miss > 0) && !hit;
      m_lock  = hit ? 1'b1 : lock_now;
    end
    m_prev = mole;
    m_en_d = enable;
    cyc++;
  endtask

  initial begin
    model_reset();
    cyc = 0;
    forever begin
      @(negedge clk_1mhz);
      if (!rst_n) model_reset();
      check("cyc_hit_pulse",  hit_pulse,  m_hit);
      check("cyc_miss_pulse", miss_pulse, m_missp);
      check("cyc_score",      score,      m_score);
      check("cyc_miss_cnt",   miss_cnt,   m_miss);
      if (rst_n) model_step();
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers: inputs change and directed checks happen 1 time unit
  // after a rising edge.
  // ---------------------------------------------------------------------
  task automatic step();
    @(posedge clk_1mhz);
    #1;
  endtask

  task automatic wait_pulse(output int lat, output bit h, output bit m);
    lat = -1; h = 0; m = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (hit_pulse || miss_pulse) begin
        lat = i; h = hit_pulse; m = miss_pulse;
        break;
      end
    end
  endtask

  task automatic count_pulses(input int n, output int nh, output int nm);
    nh = 0; nm = 0;
    repeat (n) begin
      step();
      nh += int'(hit_pulse);
      nm += int'(miss_pulse);
    end
  endtask

  // Mole appears on hole k+1 from an empty board, gets hit, then leaves.
  task automatic do_hit(input int k, output int lat, output bit h);
    bit m;
    mole_pos = 4'(k + 1);
    step();
    btn[k] = 1'b1;
    wait_pulse(lat, h, m);
    btn[k] = 1'b0;
    repeat (N + 5) step();
    mole_pos = 4'd0;
    step();
  endtask

  initial begin
    int lat, nh, nm, th, tm;
    bit h, m;

    // Reset state
    repeat (3) step();
    check("rst_hit_pulse",  hit_pulse,  0);
    check("rst_miss_pulse", miss_pulse, 0);
    check("rst_score",      score,      0);
    check("rst_miss_cnt",   miss_cnt,   0);
    rst_n = 1'b1;
    enable = 1'b1;
    mole_pos = 4'd3;
    repeat (5) step();

    // Clean press on the mole's hole, then a locked second press
    btn[2] = 1'b1;
    wait_pulse(lat, h, m);
    check("hit_latency", lat, LAT);
    check("hit_seen", h, 1);
    check("hit_no_miss", m, 0);
    check("score_first_hit", score, 1);
    repeat (10) step();
    btn[2] = 1'b0;
    repeat (N + 10) step();
    btn[2] = 1'b1;
    count_pulses(LAT + 40, nh, nm);
    check("locked_hits", nh, 0);
    check("locked_misses", nm, 0);
    check("score_locked", score, 1);
    btn[2] = 1'b0;
    repeat (N + 10) step();

    // Bouncing button: toggles every 1 ms for 8 ms, then holds
    mole_pos = 4'd0;
    step();
    mole_pos = 4'd3;
    step();
    check("no_escape_when_locked", miss_cnt, 0);
    th = 0; tm = 0;
    for (int i = 0; i < 8; i++) begin
      btn[2] = (i % 2 == 0);
      count_pulses(CPM, nh, nm);
      th += nh; tm += nm;
    end
    check("bounce_no_pulse", th + tm, 0);
    btn[2] = 1'b1;
    wait_pulse(lat, h, m);
    check("bounce_hit_latency", lat, LAT);
    check("bounce_hit_seen", h, 1);
    count_pulses(60, nh, nm);
    check("bounce_single_hit", nh + nm, 0);
    check("score_after_bounce", score, 2);
    btn[2] = 1'b0;
    repeat (N + 10) step();

    // Wrong press on an empty board, then an escape
    mole_pos = 4'd0;
    step();
    btn[0] = 1'b1;
    wait_pulse(lat, h, m);
    check("wrong_latency", lat, LAT);
    check("wrong_is_miss", m, 1);
    check("wrong_not_hit", h, 0);
    check("miss_after_wrong", miss_cnt, 1);
    btn[0] = 1'b0;
    repeat (N + 10) step();
    mole_pos = 4'd5;
    repeat (5) step();
    mole_pos = 4'd0;
    step();
    check("escape_pulse", miss_pulse, 1);
    check("miss_after_escape", miss_cnt, 2);

    // Escape and wrong press in the same cycle
    mole_pos = 4'd5;
    repeat (5) step();
    btn[0] = 1'b1;
    repeat (LAT - 1) step();
    mole_pos = 4'd0;
    step();
    check("double_miss_pulse", miss_pulse, 1);
    check("double_no_hit", hit_pulse, 0);
    check("double_miss_cnt", miss_cnt, 4);
    step();
    check("double_pulse_single", miss_pulse, 0);
    btn[0] = 1'b0;
    repeat (N + 10) step();

    // Target plus another button together: one hit only
    mole_pos = 4'd4;
    step();
    btn[3] = 1'b1;
    btn[6] = 1'b1;
    wait_pulse(lat, h, m);
    check("combo_hit", h, 1);
    check("combo_no_miss_pulse", m, 0);
    count_pulses(20, nh, nm);
    check("combo_single", nh + nm, 0);
    check("combo_score", score, 3);
    check("combo_miss_cnt", miss_cnt, 4);
    btn = '0;
    repeat (N + 10) step();
    mole_pos = 4'd0;
    step();

    // Saturation at 99
    for (int i = 0; i < 96; i++) do_hit(i % 8, lat, h);
    check("score_at_99", score, 99);
    do_hit(5, lat, h);
    check("sat_hit_pulse", h, 1);
    check("sat_hit_latency", lat, LAT);
    check("score_stays_99", score, 99);
    check("miss_after_sat", miss_cnt, 4);

    // Reset mid-game and mid-debounce
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 7; i++) do_hit(i, lat, h);
    check("score_seven", score, 7);
    mole_pos = 4'd1;
    step();
    btn[0] = 1'b1;
    repeat (30) step();
    rst_n = 1'b0;
    #1;
    check("rst_now_hit", hit_pulse, 0);
    check("rst_now_miss", miss_pulse, 0);
    check("rst_now_score", score, 0);
    check("rst_now_miss_cnt", miss_cnt, 0);
    repeat (3) step();
    rst_n = 1'b1;
    wait_pulse(lat, h, m);
    check("held_after_rst_latency", lat, LAT);
    check("held_after_rst_hit", h, 1);
    check("held_after_rst_score", score, 1);
    btn[0] = 1'b0;
    repeat (N + 5) step();
    mole_pos = 4'd0;
    step();
    for (int i = 0; i < 3; i++) do_hit(i + 3, lat, h);
    check("score_four", score, 4);
    enable = 1'b0;
    repeat (5) step();
    check("disabled_hold", score, 4);
    enable = 1'b1;
    step();
    check("enable_clears_score", score, 0);
    check("enable_clears_miss", miss_cnt, 0);

    // Randomized play against the model
    repeat (5000) begin
      step();
      if ($urandom_range(0, 59) == 0) mole_pos = 4'($urandom_range(0, 15));
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 47) == 0) btn[k] = ~btn[k];
      end
      if ($urandom_range(0, 799) == 0) enable = ~enable;
      if ($urandom_range(0, 2999) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
    end
    btn = '0;
    repeat (N + 10) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
